// File: rtl/ysyx_22040750_mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data memory (slave).
interface ysyx_22040750_mem_stage_if;
    logic        O_dmem_req_valid;
    logic        I_dmem_req_ready;
    logic [31:0] O_dmem_addr;
    logic        O_dmem_wen;
    logic [63:0] O_dmem_wdata;
    logic [7:0]  O_dmem_wstrb;
    logic        I_dmem_rsp_valid;
    logic [63:0] I_dmem_rdata;

    modport master (
        output O_dmem_req_valid,
        input  I_dmem_req_ready,
        output O_dmem_addr,
        output O_dmem_wen,
        output O_dmem_wdata,
        output O_dmem_wstrb,
        input  I_dmem_rsp_valid,
        input  I_dmem_rdata
    );

    modport slave (
        input  O_dmem_req_valid,
        output I_dmem_req_ready,
        input  O_dmem_addr,
        input  O_dmem_wen,
        input  O_dmem_wdata,
        input  O_dmem_wstrb,
        output I_dmem_rsp_valid,
        output I_dmem_rdata
    );
endinterface

// File: rtl/ysyx_22040750_mem_stage.sv
// Memory-access stage: a one-entry buffer that issues at most one data-memory
// request per instruction and presents raw load data to the MEM/WB register.
module ysyx_22040750_mem_stage #(
    parameter int SIDE_W = 184
) (
    input  logic              I_sys_clk,
    input  logic              I_rst_n,
    input  logic              I_MEM_valid,
    output logic              O_MEM_allowin,
    input  logic [63:0]       I_alu_out,
    input  logic              I_mem_ren,
    input  logic              I_mem_wen,
    input  logic [63:0]       I_mem_wdata,
    input  logic [7:0]        I_mem_wmask,
    input  logic [8:0]        I_mem_rstrb,
    input  logic [SIDE_W-1:0] I_side,
    output logic              O_MEM_WB_valid,
    input  logic              I_MEM_WB_allowin,
    output logic [63:0]       O_alu_out,
    output logic [63:0]       O_mem_data,
    output logic [8:0]        O_mem_rstrb,
    output logic [2:0]        O_mem_shamt,
    output logic [SIDE_W-1:0] O_side,
    ysyx_22040750_mem_stage_if.master dmem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              accept;
    logic              mem_op;
    logic [63:0]       alu_q;
    logic              ren_q;
    logic              wen_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wmask_q;
    logic [8:0]        rstrb_q;
    logic [SIDE_W-1:0] side_q;
    logic [63:0]       mem_data_q;
    logic [63:0]       mem_data_d;

    assign O_MEM_allowin = (state_q == S_IDLE) || ((state_q == S_HOLD) && I_MEM_WB_allowin);
    assign accept        = I_MEM_valid && O_MEM_allowin;
    assign mem_op        = I_mem_ren || I_mem_wen;

    always_comb begin
        state_d    = state_q;
        mem_data_d = mem_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = mem_op ? S_REQ : S_HOLD;
            end
            S_REQ: begin
                if (dmem.I_dmem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dmem.I_dmem_rsp_valid) begin
                    state_d    = S_HOLD;
                    mem_data_d = ren_q ? dmem.I_dmem_rdata : 64'd0;
                end
            end
            S_HOLD: begin
                if (I_MEM_WB_allowin) begin
                    if (accept) state_d = mem_op ? S_REQ : S_HOLD;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A freshly accepted instruction starts with no load data.
        if (accept) mem_data_d = 64'd0;
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= S_IDLE;
            alu_q      <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rstrb_q    <= '0;
            side_q     <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_data_q <= mem_data_d;
            if (accept) begin
                alu_q   <= I_alu_out;
                ren_q   <= I_mem_ren;
                wen_q   <= I_mem_wen;
                wdata_q <= I_mem_wdata;
                wmask_q <= I_mem_wmask;
                rstrb_q <= I_mem_rstrb;
                side_q  <= I_side;
            end
        end
    end

    // Store data and mask are lane-shifted to the byte offset within the doubleword.
    assign dmem.O_dmem_req_valid = (state_q == S_REQ);
    assign dmem.O_dmem_addr      = alu_q[31:0];
    assign dmem.O_dmem_wen       = wen_q;
    assign dmem.O_dmem_wdata     = wdata_q << {alu_q[2:0], 3'b000};
    assign dmem.O_dmem_wstrb     = wen_q ? (wmask_q << alu_q[2:0]) : 8'h00;

    assign O_MEM_WB_valid = (state_q == S_HOLD);
    assign O_alu_out      = alu_q;
    assign O_mem_data     = mem_data_q;
    assign O_mem_rstrb    = rstrb_q;
    assign O_mem_shamt    = alu_q[2:0];
    assign O_side         = side_q;

endmodule

// File: tb/tb_ysyx_22040750_mem_stage.sv
// Randomized self-checking bench for the MEM stage; expected request payloads
// and results come from a byte-lane model of the memory-stage rules.
module tb_ysyx_22040750_mem_stage;
    localparam int SIDE_W = 184;

    logic              clk = 1'b0;
    logic              rstN;
    logic              memValid;
    logic              memAllowin;
    logic [63:0]       aluOut;
    logic              memRen;
    logic              memWen;
    logic [63:0]       memWdata;
    logic [7:0]        memWmask;
    logic [8:0]        memRstrb;
    logic [SIDE_W-1:0] sideIn;
    logic              wbValid;
    logic              wbAllowin;
    logic [63:0]       outAlu;
    logic [63:0]       outMemData;
    logic [8:0]        outRstrb;
    logic [2:0]        outShamt;
    logic [SIDE_W-1:0] outSide;

    int checks = 0;
    int failures = 0;
    int hsCount = 0;
    int xferCount = 0;

    logic [63:0]       expAlu;
    logic [63:0]       expWdata;
    logic [7:0]        expWmask;
    logic [8:0]        expRstrb;
    logic [SIDE_W-1:0] expSide;
    logic              expWen;

    ysyx_22040750_mem_stage_if dmem ();

    ysyx_22040750_mem_stage #(.SIDE_W(SIDE_W)) dut (
        .I_sys_clk        (clk),
        .I_rst_n          (rstN),
        .I_MEM_valid      (memValid),
        .O_MEM_allowin    (memAllowin),
        .I_alu_out        (aluOut),
        .I_mem_ren        (memRen),
        .I_mem_wen        (memWen),
        .I_mem_wdata      (memWdata),
        .I_mem_wmask      (memWmask),
        .I_mem_rstrb      (memRstrb),
        .I_side           (sideIn),
        .O_MEM_WB_valid   (wbValid),
        .I_MEM_WB_allowin (wbAllowin),
        .O_alu_out        (outAlu),
        .O_mem_data       (outMemData),
        .O_mem_rstrb      (outRstrb),
        .O_mem_shamt      (outShamt),
        .O_side           (outSide),
        .dmem             (dmem)
    );

    always #5 clk = ~clk;

    // Count request handshakes and MEM/WB transfers as they happen on the edge.
    always @(posedge clk) begin
        if (rstN && dmem.O_dmem_req_valid && dmem.I_dmem_req_ready) hsCount <= hsCount + 1;
        if (rstN && wbValid && wbAllowin) xferCount <= xferCount + 1;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] modelWdata(input logic [63:0] d, input logic [2:0] off);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (i + int'(off) < 8) r[(i + int'(off)) * 8 +: 8] = d[i * 8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] modelWstrb(input logic [7:0] m, input logic [2:0] off, input logic isStore);
        logic [7:0] r;
        r = '0;
        if (isStore)
            for (int i = 0; i < 8; i++)
                if (i + int'(off) < 8) r[i + int'(off)] = m[i];
        return r;
    endfunction

    task automatic randSide(output logic [SIDE_W-1:0] s);
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s = t[SIDE_W-1:0];
    endtask

    task automatic randFields();
        aluOut   = {$urandom, $urandom};
        memWdata = {$urandom, $urandom};
        memWmask = 8'($urandom);
        memRstrb = 9'($urandom);
        memRen   = 1'($urandom);
        memWen   = ~memRen;
        randSide(sideIn);
    endtask

    task automatic setInstr(input logic r, input logic w, input logic [63:0] a,
                            input logic [63:0] d, input logic [7:0] m, input logic [8:0] s);
        memValid = 1'b1;
        memRen   = r;
        memWen   = w;
        aluOut   = a;
        memWdata = d;
        memWmask = m;
        memRstrb = s;
        randSide(sideIn);
        expAlu   = a;
        expWdata = d;
        expWmask = m;
        expRstrb = s;
        expSide  = sideIn;
        expWen   = w;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            memValid  = 1'($urandom);
            wbAllowin = 1'($urandom);
            randFields();
            dmem.I_dmem_req_ready = 1'($urandom);
            dmem.I_dmem_rsp_valid = 1'($urandom);
            dmem.I_dmem_rdata     = {$urandom, $urandom};
            @(negedge clk);
            checks++; if (memAllowin !== 1'b1) begin failures++; $display("[TB] FAIL reset_allowin got=%0h exp=1", memAllowin); end
            checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid got=%0h exp=0", wbValid); end
            checks++; if (dmem.O_dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%0h exp=0", dmem.O_dmem_req_valid); end
            checks++; if (outAlu !== 64'd0) begin failures++; $display("[TB] FAIL reset_alu got=%0h exp=0", outAlu); end
            checks++; if (outMemData !== 64'd0) begin failures++; $display("[TB] FAIL reset_mem_data got=%0h exp=0", outMemData); end
            checks++; if (outRstrb !== 9'd0) begin failures++; $display("[TB] FAIL reset_rstrb got=%0h exp=0", outRstrb); end
            checks++; if (outShamt !== 3'd0) begin failures++; $display("[TB] FAIL reset_shamt got=%0h exp=0", outShamt); end
            checks++; if (outSide !== '0) begin failures++; $display("[TB] FAIL reset_side got=%0h exp=0", outSide); end
            checks++; if (dmem.O_dmem_addr !== 32'd0) begin failures++; $display("[TB] FAIL reset_addr got=%0h exp=0", dmem.O_dmem_addr); end
            checks++; if (dmem.O_dmem_wen !== 1'b0) begin failures++; $display("[TB] FAIL reset_wen got=%0h exp=0", dmem.O_dmem_wen); end
            checks++; if (dmem.O_dmem_wdata !== 64'd0) begin failures++; $display("[TB] FAIL reset_wdata got=%0h exp=0", dmem.O_dmem_wdata); end
            checks++; if (dmem.O_dmem_wstrb !== 8'd0) begin failures++; $display("[TB] FAIL reset_wstrb got=%0h exp=0", dmem.O_dmem_wstrb); end
        end
        memValid = 1'b0;
        wbAllowin = 1'b1;
        dmem.I_dmem_req_ready = 1'b0;
        dmem.I_dmem_rsp_valid = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        checks++; if (memAllowin !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_allowin got=%0h exp=1", memAllowin); end
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_wb_valid got=%0h exp=0", wbValid); end
    endtask

    task automatic test_back_to_back();
        logic [SIDE_W-1:0] sideNow;
        logic [63:0]       rd;
        int                hsStart;
        hsStart = hsCount;
        wbAllowin = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            setInstr(1'b0, 1'b0, 64'(i), {$urandom, $urandom}, 8'h0F, 9'($urandom));
            sideNow = expSide;
            @(negedge clk);
            checks++; if (wbValid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d] got=%0h exp=1", i, wbValid); end
            checks++; if (outAlu !== 64'(i)) begin failures++; $display("[TB] FAIL b2b_alu[%0d] got=%0h exp=%0h", i, outAlu, i); end
            checks++; if (outSide !== sideNow) begin failures++; $display("[TB] FAIL b2b_side[%0d] got=%0h exp=%0h", i, outSide, sideNow); end
            checks++; if (dmem.O_dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_req[%0d] got=%0h exp=0", i, dmem.O_dmem_req_valid); end
            checks++; if (memAllowin !== 1'b1) begin failures++; $display("[TB] FAIL b2b_allowin[%0d] got=%0h exp=1", i, memAllowin); end
        end
        checks++; if (hsCount - hsStart !== 0) begin failures++; $display("[TB] FAIL b2b_handshakes got=%0d exp=0", hsCount - hsStart); end
        // A load accepted while the previous result leaves HOLD goes straight to REQ.
        setInstr(1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'd0, 8'hFF, 9'h1FF);
        @(negedge clk);
        memValid = 1'b0;
        checks++; if (dmem.O_dmem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_to_req_valid got=%0h exp=1", dmem.O_dmem_req_valid); end
        checks++; if (dmem.O_dmem_addr !== 32'h8000_0010) begin failures++; $display("[TB] FAIL hold_to_req_addr got=%0h exp=80000010", dmem.O_dmem_addr); end
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL hold_to_req_wb_valid got=%0h exp=0", wbValid); end
        dmem.I_dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem.I_dmem_req_ready = 1'b0;
        dmem.I_dmem_rsp_valid = 1'b1;
        rd = {$urandom, $urandom};
        dmem.I_dmem_rdata = rd;
        @(negedge clk);
        dmem.I_dmem_rsp_valid = 1'b0;
        checks++; if (outMemData !== rd) begin failures++; $display("[TB] FAIL hold_to_req_data got=%0h exp=%0h", outMemData, rd); end
        @(negedge clk);
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL hold_to_req_drain got=%0h exp=0", wbValid); end
    endtask

    task automatic test_load();
        logic [63:0] junk;
        wbAllowin = 1'b1;
        setInstr(1'b1, 1'b0, 64'h0000_0000_8000_0006, {$urandom, $urandom}, 8'hFF, 9'h0A5);
        dmem.I_dmem_req_ready = 1'b1;
        @(negedge clk);
        memValid = 1'b0;
        checks++; if (dmem.O_dmem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL load_req_valid got=%0h exp=1", dmem.O_dmem_req_valid); end
        checks++; if (dmem.O_dmem_addr !== 32'h8000_0006) begin failures++; $display("[TB] FAIL load_addr got=%0h exp=80000006", dmem.O_dmem_addr); end
        checks++; if (dmem.O_dmem_wstrb !== 8'h00) begin failures++; $display("[TB] FAIL load_wstrb got=%0h exp=0", dmem.O_dmem_wstrb); end
        checks++; if (dmem.O_dmem_wen !== 1'b0) begin failures++; $display("[TB] FAIL load_wen got=%0h exp=0", dmem.O_dmem_wen); end
        checks++; if (memAllowin !== 1'b0) begin failures++; $display("[TB] FAIL load_allowin got=%0h exp=0", memAllowin); end
        @(negedge clk);
        checks++; if (dmem.O_dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL load_wait_req got=%0h exp=0", dmem.O_dmem_req_valid); end
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL load_wait_wb got=%0h exp=0", wbValid); end
        dmem.I_dmem_req_ready = 1'b0;
        dmem.I_dmem_rsp_valid = 1'b1;
        dmem.I_dmem_rdata = 64'h1122_3344_5566_7788;
        @(negedge clk);
        dmem.I_dmem_rsp_valid = 1'b0;
        junk = {$urandom, $urandom};
        dmem.I_dmem_rdata = junk;
        checks++; if (wbValid !== 1'b1) begin failures++; $display("[TB] FAIL load_hold_valid got=%0h exp=1", wbValid); end
        checks++; if (outMemData !== 64'h1122_3344_5566_7788) begin failures++; $display("[TB] FAIL load_data got=%0h exp=1122334455667788", outMemData); end
        checks++; if (outShamt !== 3'd6) begin failures++; $display("[TB] FAIL load_shamt got=%0h exp=6", outShamt); end
        checks++; if (outRstrb !== 9'h0A5) begin failures++; $display("[TB] FAIL load_rstrb got=%0h exp=a5", outRstrb); end
        checks++; if (outAlu !== 64'h8000_0006) begin failures++; $display("[TB] FAIL load_alu got=%0h exp=80000006", outAlu); end
        checks++; if (outSide !== expSide) begin failures++; $display("[TB] FAIL load_side got=%0h exp=%0h", outSide, expSide); end
        @(negedge clk);
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL load_drain got=%0h exp=0", wbValid); end
    endtask

    task automatic test_store();
        wbAllowin = 1'b1;
        setInstr(1'b0, 1'b1, 64'h0000_0000_8000_0004, 64'h0000_0000_0000_AABB, 8'h03, 9'h000);
        dmem.I_dmem_req_ready = 1'b1;
        @(negedge clk);
        memValid = 1'b0;
        checks++; if (dmem.O_dmem_addr !== 32'h8000_0004) begin failures++; $display("[TB] FAIL store_addr got=%0h exp=80000004", dmem.O_dmem_addr); end
        checks++; if (dmem.O_dmem_wdata !== 64'h0000_AABB_0000_0000) begin failures++; $display("[TB] FAIL store_wdata got=%0h exp=0000aabb00000000", dmem.O_dmem_wdata); end
        checks++; if (dmem.O_dmem_wstrb !== 8'h30) begin failures++; $display("[TB] FAIL store_wstrb got=%0h exp=30", dmem.O_dmem_wstrb); end
        checks++; if (dmem.O_dmem_wen !== 1'b1) begin failures++; $display("[TB] FAIL store_wen got=%0h exp=1", dmem.O_dmem_wen); end
        @(negedge clk);
        dmem.I_dmem_req_ready = 1'b0;
        dmem.I_dmem_rsp_valid = 1'b1;
        dmem.I_dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        dmem.I_dmem_rsp_valid = 1'b0;
        checks++; if (wbValid !== 1'b1) begin failures++; $display("[TB] FAIL store_hold_valid got=%0h exp=1", wbValid); end
        checks++; if (outMemData !== 64'd0) begin failures++; $display("[TB] FAIL store_data got=%0h exp=0", outMemData); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [63:0] good;
        logic [63:0] wdExp;
        int          hsStart;
        int          xferStart;
        hsStart = hsCount;
        xferStart = xferCount;
        wbAllowin = 1'b1;
        setInstr(1'b1, 1'b0, {32'h0, 32'h8000_1003}, {$urandom, $urandom}, 8'hFF, 9'($urandom));
        wdExp = modelWdata(expWdata, expAlu[2:0]);
        dmem.I_dmem_req_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            checks++; if (dmem.O_dmem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_req_valid[%0d] got=%0h exp=1", c, dmem.O_dmem_req_valid); end
            checks++; if (dmem.O_dmem_addr !== 32'h8000_1003) begin failures++; $display("[TB] FAIL stall_addr[%0d] got=%0h exp=80001003", c, dmem.O_dmem_addr); end
            checks++; if (dmem.O_dmem_wdata !== wdExp) begin failures++; $display("[TB] FAIL stall_wdata[%0d] got=%0h exp=%0h", c, dmem.O_dmem_wdata, wdExp); end
            checks++; if (dmem.O_dmem_wstrb !== 8'h00) begin failures++; $display("[TB] FAIL stall_wstrb[%0d] got=%0h exp=0", c, dmem.O_dmem_wstrb); end
            checks++; if (memAllowin !== 1'b0) begin failures++; $display("[TB] FAIL stall_allowin[%0d] got=%0h exp=0", c, memAllowin); end
            memValid = 1'($urandom);
            randFields();
            @(negedge clk);
        end
        memValid = 1'b0;
        // Response arriving together with the handshake must be ignored.
        dmem.I_dmem_req_ready = 1'b1;
        dmem.I_dmem_rsp_valid = 1'b1;
        dmem.I_dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL stall_early_rsp got=%0h exp=0", wbValid); end
        checks++; if (memAllowin !== 1'b0) begin failures++; $display("[TB] FAIL stall_wait_allowin got=%0h exp=0", memAllowin); end
        dmem.I_dmem_req_ready = 1'b0;
        good = {$urandom, $urandom};
        dmem.I_dmem_rdata = good;
        wbAllowin = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            dmem.I_dmem_rsp_valid = 1'($urandom);
            dmem.I_dmem_rdata = {$urandom, $urandom};
            checks++; if (wbValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d] got=%0h exp=1", c, wbValid); end
            checks++; if (outMemData !== good) begin failures++; $display("[TB] FAIL bp_data[%0d] got=%0h exp=%0h", c, outMemData, good); end
            checks++; if (outSide !== expSide) begin failures++; $display("[TB] FAIL bp_side[%0d] got=%0h exp=%0h", c, outSide, expSide); end
            checks++; if (memAllowin !== 1'b0) begin failures++; $display("[TB] FAIL bp_allowin[%0d] got=%0h exp=0", c, memAllowin); end
            if (c == 1) wbAllowin = 1'b1;
            @(negedge clk);
        end
        dmem.I_dmem_rsp_valid = 1'b0;
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain got=%0h exp=0", wbValid); end
        checks++; if (hsCount - hsStart !== 1) begin failures++; $display("[TB] FAIL stall_handshakes got=%0d exp=1", hsCount - hsStart); end
        checks++; if (xferCount - xferStart !== 1) begin failures++; $display("[TB] FAIL stall_transfers got=%0d exp=1", xferCount - xferStart); end
    endtask

    task automatic test_reset_mid_wait();
        wbAllowin = 1'b1;
        setInstr(1'b1, 1'b0, {$urandom, $urandom}, 64'd0, 8'hFF, 9'($urandom));
        dmem.I_dmem_req_ready = 1'b1;
        @(negedge clk);
        memValid = 1'b0;
        @(negedge clk);
        dmem.I_dmem_req_ready = 1'b0;
        rstN = 1'b0;
        #1;
        checks++; if (memAllowin !== 1'b1) begin failures++; $display("[TB] FAIL midrst_allowin got=%0h exp=1", memAllowin); end
        checks++; if (dmem.O_dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_req got=%0h exp=0", dmem.O_dmem_req_valid); end
        checks++; if (outAlu !== 64'd0) begin failures++; $display("[TB] FAIL midrst_alu got=%0h exp=0", outAlu); end
        @(negedge clk);
        rstN = 1'b1;
        dmem.I_dmem_rsp_valid = 1'b1;
        dmem.I_dmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        dmem.I_dmem_rsp_valid = 1'b0;
        checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_wb_valid got=%0h exp=0", wbValid); end
        checks++; if (outMemData !== 64'd0) begin failures++; $display("[TB] FAIL midrst_data got=%0h exp=0", outMemData); end
        checks++; if (memAllowin !== 1'b1) begin failures++; $display("[TB] FAIL midrst_idle got=%0h exp=1", memAllowin); end
    endtask

    task automatic test_random();
        logic [7:0]  maskTab [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};
        logic [63:0] a;
        logic [63:0] rd;
        logic [63:0] expData;
        logic [63:0] wdExp;
        logic [7:0]  wsExp;
        int          kind;
        int          rdyDly;
        int          rspDly;
        int          stall;
        for (int n = 0; n < 40; n++) begin
            kind   = int'($urandom_range(0, 2));
            rdyDly = int'($urandom_range(0, 3));
            rspDly = int'($urandom_range(0, 2));
            stall  = int'($urandom_range(0, 2));
            a = {$urandom, $urandom};
            setInstr(kind == 1, kind == 2, a, {$urandom, $urandom}, maskTab[$urandom_range(0, 3)], 9'($urandom));
            wdExp = modelWdata(expWdata, expAlu[2:0]);
            wsExp = modelWstrb(expWmask, expAlu[2:0], expWen);
            expData = 64'd0;
            wbAllowin = (stall == 0);
            dmem.I_dmem_req_ready = 1'b0;
            @(negedge clk);
            memValid = 1'b0;
            if (kind != 0) begin
                for (int c = 0; c <= rdyDly; c++) begin
                    checks++; if (dmem.O_dmem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL rnd_req_valid[%0d] got=%0h exp=1", n, dmem.O_dmem_req_valid); end
                    checks++; if (dmem.O_dmem_addr !== expAlu[31:0]) begin failures++; $display("[TB] FAIL rnd_addr[%0d] got=%0h exp=%0h", n, dmem.O_dmem_addr, expAlu[31:0]); end
                    checks++; if (dmem.O_dmem_wdata !== wdExp) begin failures++; $display("[TB] FAIL rnd_wdata[%0d] got=%0h exp=%0h", n, dmem.O_dmem_wdata, wdExp); end
                    checks++; if (dmem.O_dmem_wstrb !== wsExp) begin failures++; $display("[TB] FAIL rnd_wstrb[%0d] got=%0h exp=%0h", n, dmem.O_dmem_wstrb, wsExp); end
                    checks++; if (dmem.O_dmem_wen !== expWen) begin failures++; $display("[TB] FAIL rnd_wen[%0d] got=%0h exp=%0h", n, dmem.O_dmem_wen, expWen); end
                    randFields();
                    dmem.I_dmem_req_ready = (c == rdyDly);
                    @(negedge clk);
                end
                dmem.I_dmem_req_ready = 1'b0;
                for (int c = 0; c <= rspDly; c++) begin
                    checks++; if (wbValid !== 1'b0 || dmem.O_dmem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rnd_wait[%0d] got=%0h%0h exp=00", n, wbValid, dmem.O_dmem_req_valid); end
                    rd = {$urandom, $urandom};
                    dmem.I_dmem_rdata = rd;
                    dmem.I_dmem_rsp_valid = (c == rspDly);
                    if (kind == 1) expData = rd;
                    @(negedge clk);
                end
                dmem.I_dmem_rsp_valid = 1'b0;
            end
            for (int c = 0; c <= stall; c++) begin
                checks++; if (wbValid !== 1'b1) begin failures++; $display("[TB] FAIL rnd_hold_valid[%0d] got=%0h exp=1", n, wbValid); end
                checks++; if (outAlu !== expAlu) begin failures++; $display("[TB] FAIL rnd_alu[%0d] got=%0h exp=%0h", n, outAlu, expAlu); end
                checks++; if (outShamt !== expAlu[2:0]) begin failures++; $display("[TB] FAIL rnd_shamt[%0d] got=%0h exp=%0h", n, outShamt, expAlu[2:0]); end
                checks++; if (outRstrb !== expRstrb) begin failures++; $display("[TB] FAIL rnd_rstrb[%0d] got=%0h exp=%0h", n, outRstrb, expRstrb); end
                checks++; if (outSide !== expSide) begin failures++; $display("[TB] FAIL rnd_side[%0d] got=%0h exp=%0h", n, outSide, expSide); end
                if (kind != 0) begin
                    checks++; if (outMemData !== expData) begin failures++; $display("[TB] FAIL rnd_data[%0d] got=%0h exp=%0h", n, outMemData, expData); end
                end
                wbAllowin = (c == stall);
                @(negedge clk);
            end
            checks++; if (wbValid !== 1'b0) begin failures++; $display("[TB] FAIL rnd_drain[%0d] got=%0h exp=0", n, wbValid); end
            wbAllowin = 1'b1;
        end
    endtask

    initial begin
        memValid = 1'b0;
        wbAllowin = 1'b1;
        randFields();
        dmem.I_dmem_req_ready = 1'b0;
        dmem.I_dmem_rsp_valid = 1'b0;
        dmem.I_dmem_rdata = 64'd0;
        test_reset();
        test_back_to_back();
        test_load();
        test_store();
        test_stall();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_mem_stage.md
# ysyx_22040750_mem_stage

Memory-access stage of the full-pipeline core: takes an instruction from the EX/MEM pipeline register, issues at most one data-memory request, and waits for its response. It then presents the raw load data, byte strobe, shift amount and pass-through fields to the MEM/WB register. It buffers exactly one instruction and uses the same valid/allowin handshake as the pipeline registers on both sides.

## Interface
- SIDE_W, 184: width of the pass-through bundle (pc, reg_wen, rd_addr, regin_sel, csr_addr, csr_wen, csr_intr, csr_mtip, csr_intr_no, csr_mret, csr), carried unmodified.
- I_sys_clk  input  1  clock; all state changes on the rising edge.
- I_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- I_MEM_valid  input  1  the EX/MEM register holds a valid instruction.
- O_MEM_allowin  output  1  this stage accepts an instruction this cycle.
- I_alu_out  input  64  ALU result; bits [31:0] are the memory address for memory ops.
- I_mem_ren / I_mem_wen  input  1 each  load / store; never both 1.
- I_mem_wdata  input  64  store data, LSB-aligned.
- I_mem_wmask  input  8  store byte mask, LSB-aligned (0x01/0x03/0x0F/0xFF).
- I_mem_rstrb  input  9  load strobe, passed through.
- I_side  input  SIDE_W  pass-through bundle.
- O_MEM_WB_valid  output  1  result valid to MEM/WB.
- I_MEM_WB_allowin  input  1  MEM/WB accepts this cycle.
- O_alu_out 64, O_mem_data 64, O_mem_rstrb 9, O_mem_shamt 3, O_side SIDE_W  outputs  held stage results.
- O_dmem_req_valid  output  1  request valid.
- I_dmem_req_ready  input  1  memory accepts the request.
- O_dmem_addr 32, O_dmem_wen 1, O_dmem_wdata 64, O_dmem_wstrb 8  outputs  request payload.
- I_dmem_rsp_valid  input  1  response valid (load data or store ack).
- I_dmem_rdata  input  64  load data, 8-byte-aligned doubleword.

## Operation
- State: IDLE (empty), REQ (request pending), WAIT (awaiting response), HOLD (result presented).
- O_MEM_allowin = IDLE || (HOLD && I_MEM_WB_allowin); combinational.
- Accept when I_MEM_valid && O_MEM_allowin: latch all inputs.
  - If the instruction is a memory op, the next state is REQ.
  - If it is not a memory op, the next state is HOLD.
- REQ: O_dmem_req_valid=1.
  - O_dmem_addr = latched alu_out[31:0].
  - O_dmem_wdata = wdata << (8*addr[2:0]).
  - O_dmem_wstrb = (wmask << addr[2:0])[7:0]; 0 for loads.
  - O_dmem_wen = latched wen.
  - Payload is stable until the handshake. On I_dmem_req_ready, go to WAIT.
- WAIT: on I_dmem_rsp_valid, capture rdata into O_mem_data for loads (0 for stores), then go to HOLD.
- HOLD: O_MEM_WB_valid=1 and outputs are stable.
  - On I_MEM_WB_allowin with a simultaneous accept: load the new instruction and go to REQ or HOLD.
  - On I_MEM_WB_allowin without an accept: go to IDLE.
- O_mem_shamt = latched alu_out[2:0]. O_alu_out, O_mem_rstrb and O_side are latched copies.
- I_dmem_rsp_valid outside WAIT is ignored; no response is accepted in the same cycle as its request handshake.

## Timing
- Reset (async assert, sync-safe deassert) forces the following, which also hold until the first accept:
  - state IDLE.
  - All latched/output registers 0.
  - O_dmem_req_valid=0, O_MEM_WB_valid=0, O_MEM_allowin=1.
- Non-memory op: accepted at edge k, O_MEM_WB_valid high in cycle k+1. Throughput is 1 per cycle with I_MEM_WB_allowin=1.
- Memory op, ready=1 and response one cycle later: accept at edge k; REQ in cycle k+1; WAIT in cycle k+2 (response arrives); HOLD in cycle k+3.
- Reset asserted mid-REQ/WAIT: return to IDLE immediately and drop the transaction. Memory is reset with the core.
- MEM/WB backpressure in HOLD keeps all outputs unchanged indefinitely.

## Test plan
- Reset with I_rst_n=0 and random inputs -> state IDLE, all outputs 0, O_MEM_allowin=1; 0 also while reset is held.
- Four back-to-back non-memory ops with alu_out=1..4 and I_MEM_WB_allowin=1 -> O_MEM_WB_valid every cycle; O_alu_out=1,2,3,4 one cycle after each accept; no dmem request.
- Load, alu_out=0x80000006, rstrb passed through, rdata=0x1122334455667788 -> addr 0x80000006, wstrb 0x00, shamt=6, O_mem_data=0x1122334455667788 in HOLD.
- Store, alu_out=0x80000004, wdata=0xAABB, wmask=0x03 -> wdata=0x0000AABB00000000, wstrb=0x30, wen=1; O_mem_data=0 after the ack.
- I_dmem_req_ready low for 3 cycles, then I_MEM_WB_allowin low for 2 cycles in HOLD:
  - payload is stable during the ready stall and O_MEM_allowin=0 throughout;
  - exactly one request handshake occurs;
  - the result transfers on the first allowin.
- I_rst_n pulsed low during WAIT, then I_dmem_rsp_valid=1 -> IDLE, response ignored, O_MEM_WB_valid stays 0.
